// File: rtl/change_dispenser.sv
// Coin payout stage: turns a vend strobe plus change amount into timed dime/nickel
// solenoid pulses, tracking tube inventory and flagging shortfall, low change and lost strobes.
module change_dispenser #(
   parameter int PULSE_CYCLES = 4,
   parameter int GAP_CYCLES   = 2,
   parameter int INV_W        = 6,
   parameter int NICKEL_INIT  = 20,
   parameter int DIME_INIT    = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       soda_in,
   input  logic [3:0] change_in,
   input  logic       restock,
   output logic       busy,
   output logic       dime_sol,
   output logic       nickel_sol,
   output logic       dispense_done,
   output logic [3:0] shortfall,
   output logic       low_change,
   output logic       overrun
);

   localparam int MAXC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic [2:0] {S_IDLE, S_SELECT, S_PULSE, S_GAP, S_DONE} state_t;

   state_t             state, state_nx;
   logic [3:0]         remaining;
   logic [INV_W-1:0]   nickel_cnt, dime_cnt;
   logic               sel_dime;
   logic [CW-1:0]      cyc;
   logic               pick_dime, pick_nickel, pulse_end, gap_end;

   always_comb begin
      pick_dime   = (remaining >= 4'd2) && (dime_cnt != '0);
      pick_nickel = !pick_dime && (remaining != 4'd0) && (nickel_cnt != '0);
      pulse_end   = (cyc == CW'(PULSE_CYCLES - 1));
      gap_end     = (cyc == CW'(GAP_CYCLES - 1));
   end

   always_ff @(posedge clk) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (soda_in) state_nx = S_SELECT;
         S_SELECT: state_nx = (pick_dime || pick_nickel) ? S_PULSE : S_DONE;
         S_PULSE:  if (pulse_end) state_nx = S_GAP;
         S_GAP:    if (gap_end) state_nx = S_SELECT;
         S_DONE:   state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         remaining  <= '0;
         nickel_cnt <= INV_W'(NICKEL_INIT);
         dime_cnt   <= INV_W'(DIME_INIT);
         sel_dime   <= 1'b0;
         cyc        <= '0;
         overrun    <= 1'b0;
      end else begin
         // a strobe outside IDLE is dropped, including in the DONE cycle
         if (soda_in && state != S_IDLE) overrun <= 1'b1;
         case (state)
            S_IDLE: begin
               if (soda_in) begin
                  remaining <= change_in;
               end else if (restock) begin
                  nickel_cnt <= INV_W'(NICKEL_INIT);
                  dime_cnt   <= INV_W'(DIME_INIT);
               end
            end
            S_SELECT: begin
               cyc <= '0;
               if (pick_dime) begin
                  remaining <= remaining - 4'd2;
                  dime_cnt  <= dime_cnt - INV_W'(1);
                  sel_dime  <= 1'b1;
               end else if (pick_nickel) begin
                  remaining  <= remaining - 4'd1;
                  nickel_cnt <= nickel_cnt - INV_W'(1);
                  sel_dime   <= 1'b0;
               end
            end
            S_PULSE: cyc <= pulse_end ? '0 : cyc + CW'(1);
            S_GAP:   cyc <= gap_end ? '0 : cyc + CW'(1);
            S_DONE:  remaining <= '0;
            default: ;
         endcase
      end
   end

   always_comb begin
      busy          = (state != S_IDLE);
      dime_sol      = (state == S_PULSE) && sel_dime;
      nickel_sol    = (state == S_PULSE) && !sel_dime;
      dispense_done = (state == S_DONE);
      shortfall     = (state == S_DONE) ? remaining : 4'd0;
      low_change    = (nickel_cnt == '0);
   end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: table-driven single transactions, hand-written corner
// sequences, and a randomized run against a transaction-level payout model.
module tb_change_dispenser;

   localparam int P = 4;
   localparam int G = 2;
   localparam int N_INIT = 20;
   localparam int D_INIT = 10;

   logic       clk = 1'b0;
   logic       reset, soda_in, restock;
   logic [3:0] change_in;
   logic       busy, dime_sol, nickel_sol, dispense_done, low_change, overrun;
   logic [3:0] shortfall;

   logic       b_reset, b_soda, b_restock;
   logic [3:0] b_change;
   logic       b_busy, b_dime, b_nickel, b_done, b_low, b_overrun;
   logic [3:0] b_short;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   change_dispenser dut (
      .clk(clk), .reset(reset), .soda_in(soda_in), .change_in(change_in), .restock(restock),
      .busy(busy), .dime_sol(dime_sol), .nickel_sol(nickel_sol), .dispense_done(dispense_done),
      .shortfall(shortfall), .low_change(low_change), .overrun(overrun)
   );

   change_dispenser #(.NICKEL_INIT(1), .DIME_INIT(0)) dut_b (
      .clk(clk), .reset(b_reset), .soda_in(b_soda), .change_in(b_change), .restock(b_restock),
      .busy(b_busy), .dime_sol(b_dime), .nickel_sol(b_nickel), .dispense_done(b_done),
      .shortfall(b_short), .low_change(b_low), .overrun(b_overrun)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic do_reset(input logic verify);
      reset = 1'b0; soda_in = 1'b0; restock = 1'b0; change_in = 4'd0;
      @(posedge clk); #1;
      if (verify) begin
         check("rst_busy", busy, 0);
         check("rst_sols", {dime_sol, nickel_sol}, 0);
         check("rst_done", dispense_done, 0);
         check("rst_short", shortfall, 0);
         check("rst_overrun", overrun, 0);
         check("rst_low", low_change, 0);
         check("rst_dimes", dut.dime_cnt, D_INIT);
         check("rst_nickels", dut.nickel_cnt, N_INIT);
      end
      reset = 1'b1;
   endtask

   // Strobe issued in cycle 0; traces indexed by cycle number. Returns in the first idle cycle.
   task automatic run_txn(input logic [3:0] chg, input int ovr_cyc, input int rs_cyc,
                          output int done_cyc, output int short_v, output int dime_hi,
                          output int nick_hi, output logic [127:0] dtr, output logic [127:0] ntr,
                          output logic [127:0] btr);
      done_cyc = -1; short_v = -1; dime_hi = 0; nick_hi = 0; dtr = '0; ntr = '0; btr = '0;
      soda_in = 1'b1; change_in = chg;
      @(posedge clk); #1;
      soda_in = 1'b0; change_in = 4'd0;
      for (int k = 1; k < 120; k++) begin
         if (dime_sol)   begin dime_hi++; dtr[k] = 1'b1; end
         if (nickel_sol) begin nick_hi++; ntr[k] = 1'b1; end
         if (busy) btr[k] = 1'b1;
         if (dispense_done) begin done_cyc = k; short_v = int'(shortfall); end
         if (!busy) break;
         restock   = (k == rs_cyc);
         soda_in   = (k == ovr_cyc);
         change_in = (k == ovr_cyc) ? 4'd5 : 4'd0;
         @(posedge clk); #1;
         restock = 1'b0; soda_in = 1'b0; change_in = 4'd0;
      end
   endtask

   typedef struct {
      logic [3:0] chg;
      int done_cyc, short_v, dimes_after, nicks_after, dime_hi, nick_hi;
   } vec_t;

   typedef struct {
      logic busy, dsol, nsol, done;
      logic [3:0] short_v;
   } exp_t;

   exp_t exp_q[$];
   int   mdime, mnick;

   // Payout model: dimes first, nickels for the rest, limited by stock.
   task automatic gen_seq(input int chg);
      int nd, nn, rem, sh;
      exp_t r;
      nd  = (chg / 2 < mdime) ? chg / 2 : mdime;
      rem = chg - 2 * nd;
      nn  = (rem < mnick) ? rem : mnick;
      sh  = rem - nn;
      mdime -= nd; mnick -= nn;
      r = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
      exp_q.push_back(r);
      for (int i = 0; i < nd + nn; i++) begin
         for (int j = 0; j < P; j++) exp_q.push_back('{1'b1, i < nd, i >= nd, 1'b0, 4'd0});
         for (int j = 0; j < G; j++) exp_q.push_back(r);
         exp_q.push_back(r);
      end
      exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 4'(sh)});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t vecs[6];
      int dc, sv, dh, nh, cnt;
      logic [127:0] dtr, ntr, btr;
      logic seen, s, r, cur_busy, ov;
      logic [3:0] chg;
      exp_t e;

      b_reset = 1'b0; b_soda = 1'b0; b_restock = 1'b0; b_change = 4'd0;
      vecs[0] = '{4'd0,  2,  0, 10, 20,  0, 0};
      vecs[1] = '{4'd1,  9,  0, 10, 19,  0, 4};
      vecs[2] = '{4'd3,  16, 0,  9, 19,  4, 4};
      vecs[3] = '{4'd4,  16, 0,  8, 20,  8, 0};
      vecs[4] = '{4'd15, 58, 0,  3, 19, 28, 4};
      vecs[5] = '{4'd6,  23, 0,  7, 20, 12, 0};

      do_reset(1'b1);
      foreach (vecs[i]) begin
         do_reset(1'b0);
         run_txn(vecs[i].chg, 0, 0, dc, sv, dh, nh, dtr, ntr, btr);
         check($sformatf("v%0d_done", i), dc, vecs[i].done_cyc);
         check($sformatf("v%0d_short", i), sv, vecs[i].short_v);
         check($sformatf("v%0d_dimes", i), dut.dime_cnt, vecs[i].dimes_after);
         check($sformatf("v%0d_nickels", i), dut.nickel_cnt, vecs[i].nicks_after);
         check($sformatf("v%0d_dime_hi", i), dh, vecs[i].dime_hi);
         check($sformatf("v%0d_nick_hi", i), nh, vecs[i].nick_hi);
         if (vecs[i].chg == 4'd3) begin
            check("t1_dime_trace", dtr, 128'h3C);
            check("t1_nick_trace", ntr, 128'h1E00);
         end
         if (vecs[i].chg == 4'd0) check("t2_busy_trace", btr, 128'h6);
      end

      // Depleted tubes: one nickel, no dimes.
      @(posedge clk); #1;
      b_reset = 1'b1;
      check("t3_low_before", b_low, 0);
      b_soda = 1'b1; b_change = 4'd4;
      @(posedge clk); #1;
      b_soda = 1'b0; b_change = 4'd0;
      dc = -1; sv = -1; dh = 0; nh = 0;
      for (int k = 1; k < 40; k++) begin
         if (b_dime) dh++;
         if (b_nickel) nh++;
         if (b_done) begin dc = k; sv = int'(b_short); end
         if (!b_busy) break;
         @(posedge clk); #1;
      end
      check("t3_nick_hi", nh, P);
      check("t3_dime_hi", dh, 0);
      check("t3_done", dc, 9);
      check("t3_short", sv, 3);
      check("t3_low_after", b_low, 1);
      check("t3_overrun", b_overrun, 0);

      // Strobe during a dime payout is lost.
      do_reset(1'b0);
      run_txn(4'd2, 4, 0, dc, sv, dh, nh, dtr, ntr, btr);
      check("t4_overrun", overrun, 1);
      check("t4_done", dc, 9);
      check("t4_dime_hi", dh, P);
      check("t4_nick_hi", nh, 0);
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (busy) seen = 1'b1;
         @(posedge clk); #1;
      end
      check("t4_no_second", seen, 0);
      check("t4_overrun_sticky", overrun, 1);
      check("t4_dimes", dut.dime_cnt, 9);

      // Reset mid-pulse abandons the transaction.
      do_reset(1'b0);
      soda_in = 1'b1; change_in = 4'd2;
      @(posedge clk); #1;
      soda_in = 1'b0; change_in = 4'd0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("t5_dime_c3", dime_sol, 1);
      check("t5_dimes_c3", dut.dime_cnt, D_INIT - 1);
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      check("t5_dime_off", dime_sol, 0);
      check("t5_idle", busy, 0);
      check("t5_dimes", dut.dime_cnt, D_INIT);
      check("t5_nickels", dut.nickel_cnt, N_INIT);
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (dispense_done || busy) seen = 1'b1;
         @(posedge clk); #1;
      end
      check("t5_no_done", seen, 0);

      // Drain nickels, restock while busy is ignored, restock in idle reloads.
      do_reset(1'b0);
      cnt = 0;
      for (int i = 0; i < N_INIT; i++) begin
         run_txn(4'd1, 0, 0, dc, sv, dh, nh, dtr, ntr, btr);
         if (nh == P && dc == 9) cnt++;
      end
      check("t6_nickel_txns", cnt, N_INIT);
      check("t6_empty", dut.nickel_cnt, 0);
      check("t6_low", low_change, 1);
      run_txn(4'd1, 0, 1, dc, sv, dh, nh, dtr, ntr, btr);
      check("t6_short", sv, 1);
      check("t6_short_done", dc, 2);
      check("t6_busy_restock", dut.nickel_cnt, 0);
      restock = 1'b1;
      @(posedge clk); #1;
      restock = 1'b0;
      check("t6_restock_n", dut.nickel_cnt, N_INIT);
      check("t6_restock_d", dut.dime_cnt, D_INIT);
      check("t6_low_clear", low_change, 0);

      // Randomized traffic against the payout model.
      do_reset(1'b0);
      mdime = D_INIT; mnick = N_INIT; cur_busy = 1'b0; ov = 1'b0;
      exp_q.delete();
      for (int c = 0; c < 3000; c++) begin
         if (!cur_busy) begin
            s = ($urandom_range(3) == 0);
            r = ($urandom_range(15) == 0);
         end else begin
            s = ($urandom_range(199) == 0);
            r = ($urandom_range(7) == 0);
         end
         chg = 4'($urandom_range(15));
         if (!cur_busy) begin
            if (s) gen_seq(int'(chg));
            else if (r) begin mdime = D_INIT; mnick = N_INIT; end
         end else if (s) ov = 1'b1;
         soda_in = s; restock = r; change_in = chg;
         @(posedge clk); #1;
         soda_in = 1'b0; restock = 1'b0; change_in = 4'd0;
         if (exp_q.size() > 0) e = exp_q.pop_front();
         else e = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
         cur_busy = e.busy;
         check("r_busy", busy, e.busy);
         check("r_dime_sol", dime_sol, e.dsol);
         check("r_nickel_sol", nickel_sol, e.nsol);
         check("r_done", dispense_done, e.done);
         check("r_short", shortfall, e.short_v);
         check("r_overrun", overrun, ov);
         if (!e.busy) begin
            check("r_low", low_change, mnick == 0);
            check("r_dimes", dut.dime_cnt, mdime);
            check("r_nickels", dut.nickel_cnt, mnick);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
